// File: rtl/decode_sched.sv
// decode_sched
// Decode-stage sequencer sitting between the fetch stage and the ID/EX
// pipeline register. Fetched instructions land in a main register, backed by
// a one-entry skid slot so fetch can run one ahead while EX stalls. The
// immediate format is decoded as an instruction enters main. Load-use hazards
// against the EX stage suppress id_valid and are counted; a flush from EX
// drops everything buffered.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   if_valid/if_ready     fetch handshake; if_instr, if_pc carried in
//   flush                 redirect from EX, clears both slots at next edge
//   ex_valid, ex_is_load, ex_rd   EX-stage occupant used for hazard check
//   ex_ready              EX accepts from decode
//   id_valid, id_instr, id_pc, id_imm_sel, id_illegal   decode outputs
//   stall_cnt             saturating count of load-use bubble cycles
//
// Configuration
//   ILLEGAL_TRAP_EN       when defined, unsupported opcodes raise id_illegal
//                         and never stall; otherwise id_illegal is tied low.

module decode_sched #(
    parameter int PC_W   = 32,
    parameter int SCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [31:0]       if_instr,
    input  logic [PC_W-1:0]   if_pc,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic              ex_is_load,
    input  logic [4:0]        ex_rd,
    input  logic              ex_ready,
    output logic              id_valid,
    output logic [31:0]       id_instr,
    output logic [PC_W-1:0]   id_pc,
    output logic [2:0]        id_imm_sel,
    output logic              id_illegal,
    output logic [SCNT_W-1:0] stall_cnt
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {EMPTY, FULL, SKID, LU_STALL} state_t;

    state_t state, next_state;

    logic [31:0]     main_instr;
    logic [PC_W-1:0] main_pc;
    logic [2:0]      main_imm_sel;
    logic            skid_valid;
    logic [31:0]     skid_instr;
    logic [PC_W-1:0] skid_pc;

    logic            main_valid, hazard, accept, transfer, main_free;
    logic            use_rs1, use_rs2;
    logic            load_main_if, load_main_skid, load_skid;
    logic [31:0]     src_instr;
    logic [PC_W-1:0] src_pc;

    function automatic logic [2:0] imm_format(input logic [6:0] opc, input logic [2:0] f3);
        logic [2:0] sel;
        sel = 3'b000;
        case (opc)
            OPC_LOAD:            sel = (f3 == 3'b100 || f3 == 3'b101) ? 3'b101 : 3'b000;
            OPC_STORE:           sel = 3'b001;
            OPC_LUI, OPC_AUIPC:  sel = 3'b010;
            OPC_JAL:             sel = 3'b011;
            OPC_BRANCH:          sel = 3'b100;
            default:             sel = 3'b000;
        endcase
        return sel;
    endfunction

    // Main is occupied in every state but EMPTY; the state machine is the
    // single record of main occupancy.
    assign main_valid = (state != EMPTY);

    always_comb begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b0;
        case (main_instr[6:0])
            OPC_LUI, OPC_AUIPC, OPC_JAL:    use_rs1 = 1'b0;
            OPC_STORE, OPC_BRANCH, OPC_OP:  use_rs2 = 1'b1;
            default:                        ;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    logic main_illegal;

    function automatic logic is_known(input logic [6:0] opc);
        return (opc == OPC_LOAD)  || (opc == OPC_STORE) || (opc == OPC_BRANCH) ||
               (opc == OPC_JAL)   || (opc == OPC_JALR)  || (opc == OPC_OPIMM)  ||
               (opc == OPC_OP)    || (opc == OPC_LUI)   || (opc == OPC_AUIPC);
    endfunction

    // Illegal instructions are trapped later, so they must not stall here.
    assign hazard = main_valid & ~main_illegal & ex_valid & ex_is_load & (ex_rd != 5'd0) &
                    ((use_rs1 & (main_instr[19:15] == ex_rd)) |
                     (use_rs2 & (main_instr[24:20] == ex_rd)));
    assign id_illegal = main_illegal;
`else
    assign hazard = main_valid & ex_valid & ex_is_load & (ex_rd != 5'd0) &
                    ((use_rs1 & (main_instr[19:15] == ex_rd)) |
                     (use_rs2 & (main_instr[24:20] == ex_rd)));
    assign id_illegal = 1'b0;
`endif

    assign if_ready  = ~skid_valid & ~flush;
    assign id_valid  = main_valid & ~hazard;
    assign accept    = if_valid & if_ready;
    assign transfer  = id_valid & ex_ready;
    assign main_free = ~main_valid | transfer;
    assign id_instr   = main_instr;
    assign id_pc      = main_pc;
    assign id_imm_sel = main_imm_sel;

    // A waiting skid entry always has priority for a freed main slot; since
    // if_ready is low while skid is full, accept and skid-move never collide.
    always_comb begin
        next_state     = state;
        load_main_if   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            next_state = EMPTY;
        end else if (main_free) begin
            if (skid_valid) begin
                load_main_skid = 1'b1;
                next_state     = FULL;
            end else if (accept) begin
                load_main_if = 1'b1;
                next_state   = FULL;
            end else begin
                next_state = EMPTY;
            end
        end else begin
            if (accept) begin
                load_skid  = 1'b1;
                next_state = SKID;
            end else begin
                next_state = skid_valid ? SKID : FULL;
            end
            if (hazard) begin
                next_state = LU_STALL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= next_state;
    end

    assign src_instr = load_main_skid ? skid_instr : if_instr;
    assign src_pc    = load_main_skid ? skid_pc    : if_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_instr   <= 32'h0000_0013;
            main_pc      <= '0;
            main_imm_sel <= 3'b000;
        end else if (load_main_if || load_main_skid) begin
            main_instr   <= src_instr;
            main_pc      <= src_pc;
            main_imm_sel <= imm_format(src_instr[6:0], src_instr[14:12]);
        end
    end

`ifdef ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              main_illegal <= 1'b0;
        else if (load_main_if || load_main_skid) main_illegal <= ~is_known(src_instr[6:0]);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid <= 1'b0;
            skid_instr <= 32'h0000_0013;
            skid_pc    <= '0;
        end else if (flush || load_main_skid) begin
            skid_valid <= 1'b0;
        end else if (load_skid) begin
            skid_valid <= 1'b1;
            skid_instr <= if_instr;
            skid_pc    <= if_pc;
        end
    end

    // A flushed bubble is not counted: the redirect makes it moot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (hazard && !flush && !(&stall_cnt))
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule
